// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: parametrised carry-lookahead adder/subtractor behind a valid/ready elastic pipeline.
// Define CLA_ADDER_FLAGS_EN to build the registered signed-overflow and zero flags.
module cla_adder_pipe #(
    parameter int WIDTH  = 24,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NG    = (WIDTH + BLOCK - 1) / BLOCK;
    localparam int MAXLV = 8;

    // Level-1 group generate/propagate; the top group is narrower when WIDTH % BLOCK != 0.
    function automatic logic [2*NG-1:0] group_gp(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p);
        logic [NG-1:0] gg, pp;
        for (int i = 0; i < NG; i++) begin
            gg[i] = 1'b0;
            pp[i] = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                if (i * BLOCK + j < WIDTH) begin
                    gg[i] = g[i*BLOCK+j] | (p[i*BLOCK+j] & gg[i]);
                    pp[i] = pp[i] & p[i*BLOCK+j];
                end
            end
        end
        return {pp, gg};
    endfunction

    // Builds the upper lookahead levels, then pushes carries back down; returns {cout, group carry-ins}.
    function automatic logic [NG:0] group_carries(input logic [NG-1:0] g1, input logic [NG-1:0] p1,
                                                  input logic c0);
        logic [NG-1:0] lg [MAXLV];
        logic [NG-1:0] lp [MAXLV];
        logic [NG-1:0] lc [MAXLV];
        int            n  [MAXLV];
        int            top;
        for (int l = 0; l < MAXLV; l++) begin
            lg[l] = '0;
            lp[l] = '0;
            lc[l] = '0;
            n[l]  = 1;
        end
        lg[0] = g1;
        lp[0] = p1;
        n[0]  = NG;
        top   = 0;
        for (int l = 1; l < MAXLV; l++) begin
            n[l] = (n[l-1] + BLOCK - 1) / BLOCK;
            if (n[l-1] > 1) begin
                top = l;
                for (int i = 0; i < NG; i++) begin
                    if (i < n[l]) begin
                        lg[l][i] = 1'b0;
                        lp[l][i] = 1'b1;
                        for (int j = 0; j < BLOCK; j++) begin
                            if (i * BLOCK + j < n[l-1]) begin
                                lg[l][i] = lg[l-1][i*BLOCK+j] | (lp[l-1][i*BLOCK+j] & lg[l][i]);
                                lp[l][i] = lp[l][i] & lp[l-1][i*BLOCK+j];
                            end
                        end
                    end
                end
            end
        end
        lc[top][0] = c0;
        for (int l = MAXLV - 1; l >= 1; l--) begin
            if (l <= top) begin
                for (int i = 0; i < NG; i++) begin
                    if (i < n[l-1]) begin
                        if (i % BLOCK == 0)
                            lc[l-1][i] = lc[l][i/BLOCK];
                        else
                            lc[l-1][i] = lg[l-1][i-1] | (lp[l-1][i-1] & lc[l-1][i-1]);
                    end
                end
            end
        end
        return {lg[top][0] | (lp[top][0] & c0), lc[0]};
    endfunction

    function automatic logic [WIDTH-1:0] bit_sum(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                                 input logic [NG-1:0] gc);
        logic             c;
        logic [WIDTH-1:0] s;
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % BLOCK == 0)
                c = gc[i/BLOCK];
            else
                c = g[i-1] | (p[i-1] & c);
            s[i] = p[i] ^ c;
        end
        return s;
    endfunction

    function automatic logic [STAGES:0] ready_chain(input logic [STAGES-1:0] v, input logic ordy);
        logic [STAGES:0] r;
        r         = '0;
        r[STAGES] = ordy;
        for (int k = STAGES - 1; k >= 0; k--)
            r[k] = ~v[k] | r[k+1];
        return r;
    endfunction

    logic [STAGES-1:0] stage_valid, up_valid, stage_load;
    logic [STAGES:0]   rdy;

    assign rdy        = ready_chain(stage_valid, out_ready);
    assign stage_load = up_valid & rdy[STAGES-1:0];
    assign in_ready   = rst_n & rdy[0];
    assign out_valid  = stage_valid[STAGES-1];

    always_comb begin
        up_valid    = '0;
        up_valid[0] = in_valid;
        for (int k = 1; k < STAGES; k++)
            up_valid[k] = stage_valid[k-1];
    end

    // A stage takes its upstream valid whenever it is ready, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage_valid <= '0;
        else
            stage_valid <= (up_valid & rdy[STAGES-1:0]) | (stage_valid & ~rdy[STAGES-1:0]);
    end

    logic [WIDTH-1:0] b_eff, p_in, g_in, sum_d;
    logic [NG-1:0]    grp_g_in, grp_p_in;
    logic             c0_in, cout_d;
`ifdef CLA_ADDER_FLAGS_EN
    logic             a_msb_d, p_msb_d;
`endif

    assign b_eff                = in_sub ? ~in_b : in_b;
    assign c0_in                = in_sub | in_cin;
    assign p_in                 = in_a ^ b_eff;
    assign g_in                 = in_a & b_eff;
    assign {grp_p_in, grp_g_in} = group_gp(g_in, p_in);

    if (STAGES == 1) begin : g_one
        logic [NG:0] gc;
        assign gc     = group_carries(grp_g_in, grp_p_in, c0_in);
        assign sum_d  = bit_sum(g_in, p_in, gc[NG-1:0]);
        assign cout_d = gc[NG];
`ifdef CLA_ADDER_FLAGS_EN
        assign a_msb_d = in_a[WIDTH-1];
        assign p_msb_d = p_in[WIDTH-1];
`endif
    end else begin : g_pipe
        logic [WIDTH-1:0] s0_p, s0_g;
        logic [NG-1:0]    s0_gg, s0_gp;
        logic             s0_c0;
        logic [NG:0]      s0_gc;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0_p  <= '0;
                s0_g  <= '0;
                s0_gg <= '0;
                s0_gp <= '0;
                s0_c0 <= 1'b0;
            end else if (stage_load[0]) begin
                s0_p  <= p_in;
                s0_g  <= g_in;
                s0_gg <= grp_g_in;
                s0_gp <= grp_p_in;
                s0_c0 <= c0_in;
            end
        end

        assign s0_gc = group_carries(s0_gg, s0_gp, s0_c0);
`ifdef CLA_ADDER_FLAGS_EN
        logic s0_a_msb;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                s0_a_msb <= 1'b0;
            else if (stage_load[0])
                s0_a_msb <= in_a[WIDTH-1];
        end
`endif

        if (STAGES == 2) begin : g_two
            assign sum_d  = bit_sum(s0_g, s0_p, s0_gc[NG-1:0]);
            assign cout_d = s0_gc[NG];
`ifdef CLA_ADDER_FLAGS_EN
            assign a_msb_d = s0_a_msb;
            assign p_msb_d = s0_p[WIDTH-1];
`endif
        end else begin : g_three
            // Resolved group carries are registered so the last stage is only the in-group ripple and XOR.
            logic [WIDTH-1:0] s1_p, s1_g;
            logic [NG:0]      s1_gc;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_p  <= '0;
                    s1_g  <= '0;
                    s1_gc <= '0;
                end else if (stage_load[1]) begin
                    s1_p  <= s0_p;
                    s1_g  <= s0_g;
                    s1_gc <= s0_gc;
                end
            end
            assign sum_d  = bit_sum(s1_g, s1_p, s1_gc[NG-1:0]);
            assign cout_d = s1_gc[NG];
`ifdef CLA_ADDER_FLAGS_EN
            logic s1_a_msb;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    s1_a_msb <= 1'b0;
                else if (stage_load[1])
                    s1_a_msb <= s0_a_msb;
            end
            assign a_msb_d = s1_a_msb;
            assign p_msb_d = s1_p[WIDTH-1];
`endif
        end
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (stage_load[STAGES-1]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

`ifdef CLA_ADDER_FLAGS_EN
    // Operand signs agree exactly when p[MSB] is 0, so overflow is that plus a sign flip in the sum.
    logic ovf_q, zero_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (stage_load[STAGES-1]) begin
            ovf_q  <= ~p_msb_d & (sum_d[WIDTH-1] ^ a_msb_d);
            zero_q <= ~|sum_d;
        end
    end
    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
`else
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: scoreboard bench for the default cla_adder_pipe plus a parameter sweep of extra instances.
module tb_cla_adder_pipe;
    localparam int ST = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [23:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [23:0] out_sum;

    int          n_checks;
    int          n_pass;
    logic        acc, deq, stall, ov;
    logic [26:0] got, exp_v;
    logic [26:0] sb_q [$];

    cla_adder_pipe #(.WIDTH(24), .BLOCK(4), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    // Sweep instances share operand buses; each sees the low WIDTH bits.
    logic [3:0]  sw_valid, sw_ir, sw_ov;
    logic [63:0] sw_a, sw_b;
    logic        sw_cin, sw_sub;
    logic [66:0] sw_out [4];
    logic [5:0]  s0_sum;
    logic [8:0]  s1_sum;
    logic [24:0] s2_sum;
    logic [25:0] s3_sum;
    logic [3:0]  s_cout, s_ovf, s_zero;
    int          sw_w  [4] = '{6, 9, 25, 26};
    int          sw_st [4] = '{1, 3, 3, 1};

    cla_adder_pipe #(.WIDTH(6), .BLOCK(2), .STAGES(1)) sw0 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[0]), .in_ready(sw_ir[0]),
        .in_a(sw_a[5:0]), .in_b(sw_b[5:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(sw_ov[0]), .out_ready(1'b1), .out_sum(s0_sum),
        .out_cout(s_cout[0]), .out_ovf(s_ovf[0]), .out_zero(s_zero[0])
    );
    cla_adder_pipe #(.WIDTH(9), .BLOCK(3), .STAGES(3)) sw1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[1]), .in_ready(sw_ir[1]),
        .in_a(sw_a[8:0]), .in_b(sw_b[8:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(sw_ov[1]), .out_ready(1'b1), .out_sum(s1_sum),
        .out_cout(s_cout[1]), .out_ovf(s_ovf[1]), .out_zero(s_zero[1])
    );
    cla_adder_pipe #(.WIDTH(25), .BLOCK(4), .STAGES(3)) sw2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[2]), .in_ready(sw_ir[2]),
        .in_a(sw_a[24:0]), .in_b(sw_b[24:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(sw_ov[2]), .out_ready(1'b1), .out_sum(s2_sum),
        .out_cout(s_cout[2]), .out_ovf(s_ovf[2]), .out_zero(s_zero[2])
    );
    cla_adder_pipe #(.WIDTH(26), .BLOCK(3), .STAGES(1)) sw3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[3]), .in_ready(sw_ir[3]),
        .in_a(sw_a[25:0]), .in_b(sw_b[25:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(sw_ov[3]), .out_ready(1'b1), .out_sum(s3_sum),
        .out_cout(s_cout[3]), .out_ovf(s_ovf[3]), .out_zero(s_zero[3])
    );

    assign sw_out[0] = {s_ovf[0], s_zero[0], 65'({s_cout[0], s0_sum})};
    assign sw_out[1] = {s_ovf[1], s_zero[1], 65'({s_cout[1], s1_sum})};
    assign sw_out[2] = {s_ovf[2], s_zero[2], 65'({s_cout[2], s2_sum})};
    assign sw_out[3] = {s_ovf[3], s_zero[3], 65'({s_cout[3], s3_sum})};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide addition of a, the effective b and the effective carry-in.
    function automatic logic [26:0] model(input logic [23:0] a, input logic [23:0] b,
                                          input logic cin, input logic sub);
        logic [23:0] be;
        logic [24:0] r;
        logic        ovf, zero;
        be   = sub ? ~b : b;
        r    = {1'b0, a} + {1'b0, be} + 25'(sub | cin);
        ovf  = 1'b0;
        zero = 1'b0;
`ifdef CLA_ADDER_FLAGS_EN
        ovf  = (a[23] == be[23]) && (r[23] != a[23]);
        zero = (r[23:0] == 24'd0);
`endif
        return {ovf, zero, r};
    endfunction

    function automatic logic [66:0] sweep_model(input logic [63:0] a, input logic [63:0] b,
                                                 input logic cin, input logic sub, input int w);
        logic [63:0] mask, am, be, sm;
        logic [64:0] r;
        logic        ovf, zero;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        be   = (sub ? ~b : b) & mask;
        r    = {1'b0, am} + {1'b0, be} + 65'(sub | cin);
        sm   = r[63:0] & mask;
        ovf  = 1'b0;
        zero = 1'b0;
`ifdef CLA_ADDER_FLAGS_EN
        ovf  = (am[w-1] == be[w-1]) && (sm[w-1] != am[w-1]);
        zero = (sm == 64'd0);
`endif
        return {ovf, zero, r};
    endfunction

    task automatic tick();
        @(negedge clk);
        acc   = in_valid && in_ready;
        deq   = out_valid && out_ready;
        stall = out_valid && !out_ready;
        ov    = out_valid;
        got   = {out_ovf, out_zero, out_cout, out_sum};
        @(posedge clk);
        #1;
    endtask

    task automatic gen_ops(input int idx);
        case (idx)
            0: begin in_a = 24'h000000; in_b = 24'hFFFFFF; in_cin = 1'b1; in_sub = 1'b0; end
            1: begin in_a = 24'hFFFFFF; in_b = 24'hFFFFFF; in_cin = 1'b1; in_sub = 1'b0; end
            2: begin in_a = 24'h800000; in_b = 24'h800000; in_cin = 1'b0; in_sub = 1'b0; end
            3: begin in_a = 24'h000001; in_b = 24'h800000; in_cin = 1'b0; in_sub = 1'b1; end
            default: begin
                in_a   = 24'($urandom);
                in_b   = 24'($urandom);
                in_cin = 1'($urandom);
                in_sub = 1'($urandom);
            end
        endcase
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready);
        else n_pass++;
        n_checks++;
        if ({out_ovf, out_zero, out_cout, out_sum} !== 27'd0)
            $display("[TB] FAIL reset_out_data got=%h want=0", {out_ovf, out_zero, out_cout, out_sum});
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready got=%b want=1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [23:0] ta  [3];
        logic [23:0] tbv [3];
        logic        tc  [3];
        logic        ts  [3];
        ta  = '{24'hFFFFFF, 24'h000005, 24'h800000};
        tbv = '{24'h000001, 24'h000007, 24'h000001};
        tc  = '{1'b0, 1'b1, 1'b0};
        ts  = '{1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = ta[i]; in_b = tbv[i]; in_cin = tc[i]; in_sub = ts[i];
            in_valid = 1'b1;
            exp_v = model(ta[i], tbv[i], tc[i], ts[i]);
            tick();
            in_valid = 1'b0;
            n_checks++;
            if (acc !== 1'b1) $display("[TB] FAIL directed%0d_accept got=%b want=1", i, acc);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b0) $display("[TB] FAIL directed%0d_early_valid got=%b want=0", i, out_valid);
            else n_pass++;
            tick();
            n_checks++;
            if (out_valid !== 1'b1) $display("[TB] FAIL directed%0d_latency got=%b want=1", i, out_valid);
            else n_pass++;
            n_checks++;
            if ({out_ovf, out_zero, out_cout, out_sum} !== exp_v)
                $display("[TB] FAIL directed%0d_result got=%h want=%h", i,
                         {out_ovf, out_zero, out_cout, out_sum}, exp_v);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int sent, recv, ticks;
        sent = 0; recv = 0; ticks = 0;
        sb_q.delete();
        out_ready = 1'b1;
        gen_ops(0);
        while (recv < 100 && ticks < 400) begin
            in_valid = (sent < 100);
            tick();
            ticks++;
            if (acc) begin
                sb_q.push_back(model(in_a, in_b, in_cin, in_sub));
                sent++;
                gen_ops(sent);
            end
            if (deq) begin
                n_checks++;
                if (sb_q.size() == 0) $display("[TB] FAIL stream_spurious got=%h want=none", got);
                else begin
                    exp_v = sb_q.pop_front();
                    if (got !== exp_v) $display("[TB] FAIL stream_beat%0d got=%h want=%h", recv, got, exp_v);
                    else n_pass++;
                end
                recv++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (ticks !== 100 + ST) $display("[TB] FAIL stream_throughput got=%0d cycles want=%0d", ticks, 100 + ST);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          sent, recv, t;
        logic        saw_drop, prev_stall;
        logic [26:0] prev_got;
        sent = 0; recv = 0; t = 0;
        saw_drop = 1'b0; prev_stall = 1'b0; prev_got = '0;
        sb_q.delete();
        gen_ops(10);
        while (recv < 8 && t < 60) begin
            out_ready = !(t >= 3 && t < 6);
            in_valid  = (sent < 8);
            tick();
            if (in_valid && !acc) saw_drop = 1'b1;
            if (prev_stall) begin
                n_checks++;
                if ({ov, got} !== {1'b1, prev_got})
                    $display("[TB] FAIL bp_hold got=%h want=%h", {ov, got}, {1'b1, prev_got});
                else n_pass++;
            end
            prev_stall = stall;
            prev_got   = got;
            if (acc) begin
                sb_q.push_back(model(in_a, in_b, in_cin, in_sub));
                sent++;
                gen_ops(10 + sent);
            end
            if (deq) begin
                n_checks++;
                if (sb_q.size() == 0) $display("[TB] FAIL bp_spurious got=%h want=none", got);
                else begin
                    exp_v = sb_q.pop_front();
                    if (got !== exp_v) $display("[TB] FAIL bp_beat%0d got=%h want=%h", recv, got, exp_v);
                    else n_pass++;
                end
                recv++;
            end
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (saw_drop !== 1'b1) $display("[TB] FAIL bp_in_ready_drop got=%b want=1", saw_drop);
        else n_pass++;
        n_checks++;
        if (recv !== 8 || sb_q.size() !== 0)
            $display("[TB] FAIL bp_count got=%0d/%0d left want=8/0", recv, sb_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nd, t;
        logic seen;
        out_ready = 1'b0;
        gen_ops(20);
        in_valid = 1'b1;
        tick();
        gen_ops(21);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) $display("[TB] FAIL rstmid_inflight got=%b want=1", out_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 24'd0)
            $display("[TB] FAIL rstmid_async got=%b/%b/%h want=0/0/0", out_valid, in_ready, out_sum);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        out_ready = 1'b1;
        nd = 0;
        repeat (5) begin
            tick();
            if (ov) nd++;
        end
        n_checks++;
        if (nd !== 0) $display("[TB] FAIL rstmid_ghost got=%0d outputs want=0", nd);
        else n_pass++;
        gen_ops(22);
        exp_v = model(in_a, in_b, in_cin, in_sub);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 10) begin
            tick();
            if (deq) seen = 1'b1;
            t++;
        end
        n_checks++;
        if (!seen || got !== exp_v) $display("[TB] FAIL rstmid_new_beat got=%h want=%h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_param_sweep();
        logic [63:0] a, b, msb;
        logic        cin, sub, acc_sw;
        int          lat, w;
        for (int d = 0; d < 4; d++) begin
            w   = sw_w[d];
            msb = 64'd1 << (w - 1);
            for (int k = 0; k < 10; k++) begin
                case (k)
                    0: begin a = '0;  b = '0;  cin = 1'b0; sub = 1'b0; end
                    1: begin a = '1;  b = '1;  cin = 1'b1; sub = 1'b0; end
                    2: begin a = 64'd1; b = '1; cin = 1'b0; sub = 1'b0; end
                    3: begin a = msb; b = msb; cin = 1'b0; sub = 1'b1; end
                    4: begin a = msb; b = 64'd1; cin = 1'b1; sub = 1'b1; end
                    default: begin
                        a   = {$urandom, $urandom};
                        b   = {$urandom, $urandom};
                        cin = 1'($urandom);
                        sub = 1'($urandom);
                    end
                endcase
                sw_a = a; sw_b = b; sw_cin = cin; sw_sub = sub;
                sw_valid = 4'(1 << d);
                @(negedge clk);
                acc_sw = sw_ir[d];
                @(posedge clk);
                #1;
                sw_valid = '0;
                n_checks++;
                if (acc_sw !== 1'b1) $display("[TB] FAIL sweep%0d_%0d_accept got=%b want=1", d, k, acc_sw);
                else n_pass++;
                lat = 1;
                while (!sw_ov[d] && lat < 8) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                n_checks++;
                if (lat !== sw_st[d]) $display("[TB] FAIL sweep%0d_%0d_latency got=%0d want=%0d", d, k, lat, sw_st[d]);
                else n_pass++;
                n_checks++;
                if (sw_out[d] !== sweep_model(a, b, cin, sub, w))
                    $display("[TB] FAIL sweep%0d_%0d_result got=%h want=%h", d, k, sw_out[d],
                             sweep_model(a, b, cin, sub, w));
                else n_pass++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        sw_valid = '0;
        sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        #12;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
